// File: rtl/cipher_xor_unit.sv
// cipher_xor_unit: XORs message words with buffered keystream words from a small FIFO.
module cipher_xor_unit #(
  parameter int KS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] keystream,
  input  logic        ks_valid,
  output logic        ks_ready,
  input  logic [31:0] pt_data,
  input  logic        pt_valid,
  input  logic        pt_last,
  output logic        pt_ready,
  output logic [31:0] ct_data,
  output logic        ct_valid,
  output logic        ct_last,
  input  logic        ct_ready,
  output logic [15:0] word_count,
  output logic        busy
);
  localparam int AW = $clog2(KS_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [31:0]   mem_q [KS_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   ct_data_q, ct_data_d;
  logic          ct_valid_q, ct_valid_d, ct_last_q, ct_last_d;
  logic [15:0]   wc_q, wc_d;
  logic          push, fire, flush;
  assign ks_ready   = (count_q < (AW+1)'(KS_DEPTH)) && (state_q != DONE);
  assign pt_ready   = (state_q == RUN) && (count_q != '0) && (!ct_valid_q || ct_ready);
  assign push       = ks_valid && ks_ready;
  assign fire       = pt_valid && pt_ready;
  // the final output word leaving DONE ends the message and discards spare keystream
  assign flush      = (state_q == DONE) && ct_valid_q && ct_ready && ct_last_q;
  assign ct_data    = ct_data_q;
  assign ct_valid   = ct_valid_q;
  assign ct_last    = ct_last_q;
  assign word_count = wc_q;
  assign busy       = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && start) state_d = RUN;
    if (state_q == RUN && fire && pt_last) state_d = DONE;
    if (flush) state_d = IDLE;
  end
  always_comb begin
    wr_ptr_d   = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d   = flush ? '0 : rd_ptr_q + AW'(fire);
    count_d    = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(fire);
    ct_data_d  = fire ? (pt_data ^ mem_q[rd_ptr_q]) : ct_data_q;
    ct_last_d  = fire ? pt_last : ct_last_q;
    ct_valid_d = fire || (ct_valid_q && !ct_ready);
    wc_d       = (state_q == IDLE && start) ? 16'd0 : wc_q + 16'(fire);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ct_data_q  <= '0;
      ct_valid_q <= 1'b0;
      ct_last_q  <= 1'b0;
      wc_q       <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ct_data_q  <= ct_data_d;
      ct_valid_q <= ct_valid_d;
      ct_last_q  <= ct_last_d;
      wc_q       <= wc_d;
    end
  end
  // storage needs no reset: only entries below count are ever read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= keystream;
  end
endmodule

// File: tb/tb_cipher_xor_unit.sv
// tb_cipher_xor_unit: directed bench with a keystream/output scoreboard for cipher_xor_unit.
module tb_cipher_xor_unit;
  logic        clk = 0, reset = 0, start = 0;
  logic [31:0] keystream = 0, pt_data = 0;
  logic        ks_valid = 0, pt_valid = 0, pt_last = 0, ct_ready = 0;
  logic        ks_ready, pt_ready, ct_valid, ct_last, busy;
  logic [31:0] ct_data;
  logic [15:0] word_count;
  int          checks = 0, errors = 0;
  bit          ks_auto = 0;
  logic [31:0] ksq [$];
  logic [32:0] expq [$];

  cipher_xor_unit #(.KS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .keystream(keystream), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .pt_data(pt_data), .pt_valid(pt_valid), .pt_last(pt_last), .pt_ready(pt_ready),
    .ct_data(ct_data), .ct_valid(ct_valid), .ct_last(ct_last), .ct_ready(ct_ready),
    .word_count(word_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ks_auto) keystream = $urandom;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    logic ok;
    ok = 0;
    pt_valid = 1;
    pt_data  = d;
    pt_last  = l;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = pt_ready;
      tick();
    end
    chk("send_accept", 32'(ok), 1);
    pt_valid = 0;
    pt_last  = 0;
  endtask

  // Inputs only change just after a rising edge, so negedge sees what the next edge will accept.
  always @(negedge clk) begin
    logic [32:0] e;
    logic [31:0] k;
    if (!reset) begin
      ksq.delete();
      expq.delete();
    end else begin
      if (ct_valid && ct_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_unexpected observed=%h expected=none", ct_data);
        end else begin
          e = expq.pop_front();
          checks++;
          assert ({ct_last, ct_data} === e) else begin
            errors++;
            $error("FAIL sb_out observed=%h expected=%h", {ct_last, ct_data}, e);
          end
        end
        if (ct_last) ksq.delete();
      end
      if (pt_valid && pt_ready) begin
        if (ksq.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_ks_empty observed=fire expected=no_fire");
        end else begin
          k = ksq.pop_front();
          expq.push_back({pt_last, pt_data ^ k});
        end
      end
      if (ks_valid && ks_ready) ksq.push_back(keystream);
    end
  end

  initial begin
    int n;
    #3;
    chk("rst_ks_ready", 32'(ks_ready), 1);
    chk("rst_pt_ready", 32'(pt_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ct_valid", 32'(ct_valid), 0);
    chk("rst_ct_data", ct_data, 0);
    chk("rst_wc", 32'(word_count), 0);
    tick();
    reset = 1;
    // basic single-word message
    ks_valid = 1; keystream = 32'hA5A5A5A5; tick();
    ks_valid = 0; start = 1; tick();
    start = 0; pt_valid = 1; pt_data = 32'h0F0F0F0F; pt_last = 1; ct_ready = 0;
    @(negedge clk); chk("basic_pt_ready", 32'(pt_ready), 1);
    tick();
    pt_valid = 0; pt_last = 0;
    @(negedge clk);
    chk("basic_ct_valid", 32'(ct_valid), 1);
    chk("basic_ct_data", ct_data, 32'hAAAAAAAA);
    chk("basic_ct_last", 32'(ct_last), 1);
    chk("basic_wc", 32'(word_count), 1);
    chk("done_pt_ready", 32'(pt_ready), 0);
    chk("done_ks_ready", 32'(ks_ready), 0);
    tick();
    ct_ready = 1;
    tick();
    @(negedge clk);
    chk("basic_idle", 32'(busy), 0);
    chk("basic_ct_clear", 32'(ct_valid), 0);
    // full FIFO, then 8 words across pointer wrap
    tick();
    ks_valid = 1;
    for (int i = 0; i < 4; i++) begin keystream = 32'hC0DE0000 + i; tick(); end
    keystream = 32'hC0DE0004;
    @(negedge clk); chk("full_ks_ready", 32'(ks_ready), 0);
    tick();
    start = 1; tick();
    start = 0; pt_valid = 1; pt_data = 32'h00000000; pt_last = 0;
    @(negedge clk);
    chk("full_pt_ready", 32'(pt_ready), 1);
    chk("full_ks_ready_run", 32'(ks_ready), 0);
    tick();
    pt_valid = 0;
    @(negedge clk); chk("full_ks_ready_after_pop", 32'(ks_ready), 1);
    tick();
    ks_auto = 1;
    for (int i = 0; i < 7; i++) send($urandom, i == 6);
    ks_valid = 0; ks_auto = 0;
    tick(); tick();
    @(negedge clk); chk("full_idle", 32'(busy), 0);
    tick();
    // backpressure, then flush of two leftover words
    ks_valid = 1;
    keystream = 32'h11111111; tick();
    keystream = 32'h22222222; tick();
    keystream = 32'h33333333; tick();
    keystream = 32'h44444444; tick();
    ks_valid = 0; start = 1; tick();
    start = 0; ct_ready = 0;
    send(32'h01010101, 0);
    pt_valid = 1; pt_data = 32'h0F0F0F0F; pt_last = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ct_data", ct_data, 32'h10101010);
      chk("bp_ct_valid", 32'(ct_valid), 1);
      chk("bp_pt_ready", 32'(pt_ready), 0);
      chk("bp_wc", 32'(word_count), 1);
      tick();
    end
    ct_ready = 1;
    @(negedge clk); chk("bp_release", 32'(pt_ready), 1);
    tick();
    pt_valid = 0; pt_last = 0;
    @(negedge clk);
    chk("bp_second_data", ct_data, 32'h2D2D2D2D);
    chk("bp_second_last", 32'(ct_last), 1);
    tick();
    @(negedge clk); chk("flush_idle", 32'(busy), 0);
    tick();
    // starvation: flushed FIFO is empty, so no fire until a word lands
    start = 1; tick();
    start = 0; pt_valid = 1; pt_data = 32'h12345678; pt_last = 1;
    @(negedge clk); chk("starve_flushed", 32'(pt_ready), 0);
    tick();
    @(negedge clk); chk("starve_wait", 32'(pt_ready), 0);
    tick();
    ks_valid = 1; keystream = 32'h87654321;
    @(negedge clk); chk("starve_no_bypass", 32'(pt_ready), 0);
    tick();
    ks_valid = 0;
    @(negedge clk); chk("starve_next", 32'(pt_ready), 1);
    tick();
    pt_valid = 0; pt_last = 0;
    @(negedge clk); chk("starve_data", ct_data, 32'h95511559);
    tick(); tick();
    // asynchronous reset mid-message
    ks_valid = 1;
    keystream = 32'hAAAA0001; tick();
    keystream = 32'hAAAA0002; tick();
    ks_valid = 0; start = 1; tick();
    start = 0; ct_ready = 0;
    send(32'h00000005, 0);
    @(negedge clk); chk("arst_pre_valid", 32'(ct_valid), 1);
    #2 reset = 0;
    #1;
    chk("arst_ct_valid", 32'(ct_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ct_data", ct_data, 0);
    chk("arst_wc", 32'(word_count), 0);
    chk("arst_ks_ready", 32'(ks_ready), 1);
    chk("arst_pt_ready", 32'(pt_ready), 0);
    tick(); tick();
    reset = 1; ct_ready = 1;
    tick();
    @(negedge clk); chk("arst_stay_idle", 32'(busy), 0);
    tick();
    start = 1; tick();
    start = 0; pt_valid = 1; pt_data = 32'hDEADBEEF; pt_last = 1;
    @(negedge clk); chk("arst_discarded", 32'(pt_ready), 0);
    tick();
    ks_valid = 1; keystream = 32'h01234567; tick();
    ks_valid = 0;
    send(32'hDEADBEEF, 1);
    tick(); tick();
    // word_count wrap at full throughput
    ks_auto = 1; ks_valid = 1;
    start = 1; tick();
    start = 0; pt_valid = 1; pt_last = 0;
    n = 0;
    while (word_count !== 16'hFFFF && n < 70000) begin
      pt_data = $urandom;
      tick();
      n++;
    end
    chk("wrap_preload", 32'(word_count), 32'h0000FFFF);
    pt_data = $urandom; pt_last = 1;
    @(negedge clk); chk("wrap_pt_ready", 32'(pt_ready), 1);
    tick();
    pt_valid = 0; pt_last = 0; ks_valid = 0; ks_auto = 0;
    @(negedge clk);
    chk("wrap_wc", 32'(word_count), 0);
    chk("wrap_last", 32'(ct_last), 1);
    tick(); tick();
    @(negedge clk);
    chk("wrap_idle", 32'(busy), 0);
    chk("sb_drained", 32'(expq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cipher_xor_unit.md
CIPHER_XOR_UNIT -- requirements
Module: cipher_xor_unit

Interface
REQ-001 SHALL have parameter KS_DEPTH, default 4, the keystream FIFO depth in 32-bit words (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, one-cycle request to begin a message; ignored outside IDLE.
REQ-005 SHALL have port keystream, input, 32, keystream word from the stream cipher.
REQ-006 SHALL have port ks_valid, input, 1, meaning keystream holds a valid word.
REQ-007 SHALL have port ks_ready, output, 1, meaning the unit accepts keystream this cycle.
REQ-008 SHALL have port pt_data, input, 32, plaintext (or ciphertext) word.
REQ-009 SHALL have port pt_valid and pt_last, input, 1 each, meaning the word is valid / is the final word of the message.
REQ-010 SHALL have port pt_ready, output, 1, meaning the unit accepts pt_data this cycle.
REQ-011 SHALL have port ct_data, output, 32, the XOR result.
REQ-012 SHALL have ports ct_valid and ct_last, output, 1 each, meaning the result is valid / is the final word.
REQ-013 SHALL have port ct_ready, input, 1, meaning the downstream accepts the result.
REQ-014 SHALL have port word_count, output, 16, the number of words accepted in the current message.
REQ-015 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE.
- IDLE->RUN on start=1, clearing word_count to 0.
- RUN->DONE on the cycle a pt_last=1 word is accepted.
- DONE->IDLE on the cycle ct_valid&&ct_ready with ct_last=1.
REQ-017 SHALL buffer keystream in a KS_DEPTH-entry FIFO with registered occupancy count 0..KS_DEPTH.
REQ-018 SHALL drive ks_ready = (count<KS_DEPTH) && (state!=DONE); a word is pushed when ks_valid&&ks_ready.
REQ-019 SHALL drive pt_ready = (state==RUN) && (count>0) && (!ct_valid || ct_ready).
- No same-cycle bypass: a keystream word pushed into an empty FIFO is usable no earlier than the next cycle.
REQ-020 On pt_valid&&pt_ready (a fire), SHALL pop the FIFO head and register the result on the next edge:
- ct_data = pt_data XOR head
- ct_last = pt_last
- ct_valid = 1
- Latency is exactly 1 cycle.
REQ-021 SHALL hold ct_data, ct_last and ct_valid stable while ct_valid=1 and ct_ready=0.
REQ-022 SHALL clear ct_valid on ct_ready=1 when there is no new fire in the same cycle; a fire in that cycle replaces the output, giving full throughput.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
- Pointers wrap modulo KS_DEPTH.
REQ-024 word_count SHALL increment by 1 per fire and wrap from 16'hFFFF to 0.
REQ-025 On DONE->IDLE the FIFO SHALL be flushed (count=0, pointers=0); leftover keystream is discarded.
REQ-026 start while in RUN or DONE SHALL have no effect.
REQ-027 When pt_valid=0 or pt_ready=0, SHALL not pop the FIFO and SHALL not change word_count.

Reset
REQ-028 While reset=0, regardless of clk, SHALL force:
- state=IDLE
- count=0 and both FIFO pointers=0
- ct_valid=0, ct_last=0, ct_data=0
- word_count=0
- outputs ks_ready=1, pt_ready=0, busy=0
REQ-029 Reset asserted mid-message SHALL discard all buffered data; operation resumes only after reset=1 and a new start.

Verification
REQ-030 Basic: reset; push keystream 32'hA5A5A5A5; start; pt_data=32'h0F0F0F0F, pt_last=1 -> one cycle later ct_data=32'hAAAAAAAA, ct_last=1; on ct_ready state returns to IDLE.
REQ-031 Full FIFO: with KS_DEPTH=4, push 4 words in IDLE -> ks_ready=0 with count=4; one fire -> ks_ready=1 next cycle; order preserved across pointer wrap over 8 words.
REQ-032 Backpressure: ct_ready=0 for 5 cycles with pt_valid=1 -> ct_data held constant, pt_ready=0, no FIFO pop, word_count unchanged.
REQ-033 Starvation: RUN with count=0 and pt_valid=1 -> pt_ready=0; keystream pushed at cycle t -> fire no earlier than t+1.
REQ-034 Flush and reset: 2 leftover keystream words at DONE->IDLE -> count=0. Assert reset=0 mid-RUN with ct_valid=1 -> ct_valid=0 and busy=0 immediately, without waiting for a clock edge.
REQ-035 Counter wrap: word_count preloaded by sending 65535 words, then one more fire -> word_count=0.
